// File: rtl/iir_out_stream.sv
// Output stage of the IIR filter: captures filter writes into a FIFO and
// replays them on a valid/ready stream with sequence and overflow checking.
module iir_out_stream #(
  parameter int N          = 16,
  parameter int M          = 20,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         WEN,
  input  logic [M-1:0] WAddr,
  input  logic [N-1:0] Yn,
  input  logic         Finish,
  input  logic         clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [M-1:0] out_idx,
  output logic         out_last,
  output logic         done,
  output logic         overflow,
  output logic         seq_err,
  output logic [M-1:0] sample_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  localparam logic [PW-1:0] CNT_FULL = PW'(DEPTH);
  localparam logic [PW-1:0] CNT_ONE  = PW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N-1:0] mem_d [DEPTH];
  logic [M-1:0] mem_i [DEPTH];

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] count, count_nx;
  logic [M-1:0]  exp_idx;

  logic empty, full;
  logic cap_win, push, pop;

  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign cap_win = WEN && (state == IDLE || state == RUN);
  assign pop     = !empty && out_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts
  assign push    = cap_win && (!full || pop);
  assign count_nx = count + PW'(push) - PW'(pop);

  assign out_valid = !empty;
  assign out_data  = mem_d[rptr[DEPTH_LOG2-1:0]];
  assign out_idx   = mem_i[rptr[DEPTH_LOG2-1:0]];
  assign out_last  = (state == DRAIN) && (count == CNT_ONE);
  assign done      = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (Finish)
          state_nx = (count_nx == '0) ? DONE : DRAIN;
        else if (WEN)
          state_nx = RUN;
      end
      RUN: begin
        if (Finish)
          state_nx = (count_nx == '0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (count_nx == '0)
          state_nx = DONE;
      end
      DONE: begin
        if (clr)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      exp_idx    <= '0;
      overflow   <= 1'b0;
      seq_err    <= 1'b0;
      sample_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_i[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (push) begin
        mem_d[wptr[DEPTH_LOG2-1:0]] <= Yn;
        mem_i[wptr[DEPTH_LOG2-1:0]] <= WAddr;
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr       <= rptr + PW'(1);
        sample_cnt <= sample_cnt + M'(1);
      end
      // Index tracking advances even for dropped samples
      if (cap_win) begin
        if (WAddr != exp_idx) begin
          seq_err <= 1'b1;
          exp_idx <= WAddr + M'(1);
        end else begin
          exp_idx <= exp_idx + M'(1);
        end
        if (!push)
          overflow <= 1'b1;
      end
      if (WEN && (state == DRAIN || state == DONE))
        seq_err <= 1'b1;
      if (state == DONE && clr) begin
        sample_cnt <= '0;
        overflow   <= 1'b0;
        seq_err    <= 1'b0;
        exp_idx    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iir_out_stream.sv
// Directed testbench for iir_out_stream.
// Beats accepted on the stream are logged and checked against hand values.
module tb_iir_out_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WEN = 1'b0;
  logic [19:0] WAddr = '0;
  logic [15:0] Yn = '0;
  logic        Finish = 1'b0;
  logic        clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [19:0] out_idx;
  logic        out_last;
  logic        done;
  logic        overflow;
  logic        seq_err;
  logic [19:0] sample_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] qd[$];
  logic [19:0] qi[$];
  logic        ql[$];

  iir_out_stream dut (
    .clk(clk), .rst(rst), .WEN(WEN), .WAddr(WAddr), .Yn(Yn),
    .Finish(Finish), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .done(done), .overflow(overflow),
    .seq_err(seq_err), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && out_valid && out_ready) begin
      qd.push_back(out_data);
      qi.push_back(out_idx);
      ql.push_back(out_last);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40 && !done; k++) step();
    check("done_wait", 32'(done), 32'd1);
  endtask

  task automatic do_clr();
    Finish = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_done", 32'(done), 32'd0);
    check("clr_cnt", 32'(sample_cnt), 32'd0);
    check("clr_seq", 32'(seq_err), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
  endtask

  task automatic clear_log();
    qd.delete();
    qi.delete();
    ql.delete();
  endtask

  logic [15:0] v1 [5];
  logic [19:0] gap_idx [4];
  logic [15:0] gap_val [4];
  logic        gap_se [4];
  logic        pv, pr;
  logic [15:0] pd;
  logic [19:0] pi;

  initial begin
    v1[0] = 16'd100;
    v1[1] = 16'hFF38;
    v1[2] = 16'd300;
    v1[3] = 16'hFE70;
    v1[4] = 16'd500;
    gap_idx[0] = 20'd0; gap_idx[1] = 20'd1;
    gap_idx[2] = 20'd3; gap_idx[3] = 20'd4;
    gap_val[0] = 16'd11; gap_val[1] = 16'd22;
    gap_val[2] = 16'd33; gap_val[3] = 16'd44;
    gap_se[0] = 1'b0; gap_se[1] = 1'b0;
    gap_se[2] = 1'b1; gap_se[3] = 1'b1;

    // reset state
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_seq", 32'(seq_err), 32'd0);
    check("rst_cnt", 32'(sample_cnt), 32'd0);
    rst = 1'b1;
    step();

    // basic run
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) out_ready = 1'b0;
      WEN = 1'b1;
      WAddr = 20'(i);
      Yn = v1[i];
      step();
      WEN = 1'b0;
      if (i == 0) check("latency_valid", 32'(out_valid), 32'd1);
      step();
      step();
    end
    Finish = 1'b1;
    step();
    check("b_last", 32'(out_last), 32'd1);
    check("b_last_data", 32'(out_data), 32'd500);
    out_ready = 1'b1;
    wait_done();
    check("b_nbeats", 32'(qd.size()), 32'd5);
    for (int i = 0; i < 5 && i < qd.size(); i++) begin
      check($sformatf("b_data%0d", i), 32'(qd[i]), 32'(v1[i]));
      check($sformatf("b_idx%0d", i), 32'(qi[i]), 32'(i));
      check($sformatf("b_lastf%0d", i), 32'(ql[i]), 32'(i == 4));
    end
    check("b_cnt", 32'(sample_cnt), 32'd5);
    check("b_ovf", 32'(overflow), 32'd0);
    check("b_seq", 32'(seq_err), 32'd0);
    do_clr();
    clear_log();

    // back-pressure and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      WEN = 1'b1;
      WAddr = 20'(i);
      Yn = (i == 8) ? 16'h7FFF : 16'(i * 100 + 1);
      step();
    end
    WEN = 1'b0;
    check("bp_ovf", 32'(overflow), 32'd1);
    check("bp_seq", 32'(seq_err), 32'd0);
    check("bp_head_data", 32'(out_data), 32'd1);
    check("bp_head_idx", 32'(out_idx), 32'd0);
    Finish = 1'b1;
    step();
    out_ready = 1'b1;
    wait_done();
    check("bp_nbeats", 32'(qd.size()), 32'd8);
    for (int i = 0; i < 8 && i < qd.size(); i++) begin
      check($sformatf("bp_data%0d", i), 32'(qd[i]), 32'(i * 100 + 1));
      check($sformatf("bp_idx%0d", i), 32'(qi[i]), 32'(i));
      check($sformatf("bp_lastf%0d", i), 32'(ql[i]), 32'(i == 7));
    end
    check("bp_cnt", 32'(sample_cnt), 32'd8);
    check("bp_ovf_sticky", 32'(overflow), 32'd1);
    do_clr();
    clear_log();

    // sequence gap; Finish with empty FIFO goes straight to DONE
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      WEN = 1'b1;
      WAddr = gap_idx[i];
      Yn = gap_val[i];
      step();
      WEN = 1'b0;
      check($sformatf("gap_seq%0d", i), 32'(seq_err), 32'(gap_se[i]));
      step();
    end
    Finish = 1'b1;
    step();
    check("gap_done_direct", 32'(done), 32'd1);
    check("gap_nbeats", 32'(qd.size()), 32'd4);
    for (int i = 0; i < 4 && i < qd.size(); i++) begin
      check($sformatf("gap_data%0d", i), 32'(qd[i]), 32'(gap_val[i]));
      check($sformatf("gap_idx%0d", i), 32'(qi[i]), 32'(gap_idx[i]));
      check($sformatf("gap_lastf%0d", i), 32'(ql[i]), 32'd0);
    end
    do_clr();
    clear_log();

    // simultaneous WEN and Finish
    out_ready = 1'b1;
    WEN = 1'b1; WAddr = 20'd0; Yn = 16'd7;
    step();
    WAddr = 20'd1; Yn = 16'd8;
    step();
    WAddr = 20'd2; Yn = 16'hFFFF; Finish = 1'b1;
    step();
    WEN = 1'b0;
    check("sim_last", 32'(out_last), 32'd1);
    check("sim_data", 32'(out_data), 32'h0000FFFF);
    check("sim_idx", 32'(out_idx), 32'd2);
    step();
    check("sim_done", 32'(done), 32'd1);
    check("sim_nbeats", 32'(qd.size()), 32'd3);
    if (qd.size() == 3) begin
      check("sim_lastbeat", 32'(ql[2]), 32'd1);
      check("sim_lastbeat_idx", 32'(qi[2]), 32'd2);
      check("sim_first_notlast", 32'(ql[0]), 32'd0);
    end
    check("sim_seq", 32'(seq_err), 32'd0);
    WEN = 1'b1; WAddr = 20'd3;
    step();
    WEN = 1'b0;
    check("done_wen_seq", 32'(seq_err), 32'd1);
    check("done_wen_valid", 32'(out_valid), 32'd0);
    check("done_hold", 32'(done), 32'd1);
    do_clr();
    clear_log();

    // stall stability with toggling ready
    for (int c = 0; c < 20; c++) begin
      out_ready = (c % 2) == 1;
      if (c < 4) begin
        WEN = 1'b1;
        WAddr = 20'(c);
        Yn = 16'(c * 3 + 1000);
      end else begin
        WEN = 1'b0;
      end
      pv = out_valid; pr = out_ready;
      pd = out_data;  pi = out_idx;
      step();
      if (pv && !pr) begin
        check($sformatf("stall_data_c%0d", c), 32'(out_data), 32'(pd));
        check($sformatf("stall_idx_c%0d", c), 32'(out_idx), 32'(pi));
      end
    end
    WEN = 1'b0;
    check("stall_nbeats", 32'(qd.size()), 32'd4);
    for (int i = 0; i < 4 && i < qd.size(); i++) begin
      check($sformatf("stall_bidx%0d", i), 32'(qi[i]), 32'(i));
      check($sformatf("stall_bdata%0d", i), 32'(qd[i]), 32'(i * 3 + 1000));
    end
    Finish = 1'b1;
    step();
    check("stall_done", 32'(done), 32'd1);
    check("stall_cnt", 32'(sample_cnt), 32'd4);
    do_clr();
    clear_log();

    // async reset in DRAIN
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WEN = 1'b1; WAddr = 20'(i); Yn = 16'(i + 77);
      step();
    end
    WEN = 1'b0;
    Finish = 1'b1;
    step();
    check("drain_valid", 32'(out_valid), 32'd1);
    check("drain_done", 32'(done), 32'd0);
    #3;
    rst = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_data", 32'(out_data), 32'd0);
    check("ar_idx", 32'(out_idx), 32'd0);
    check("ar_last", 32'(out_last), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_cnt", 32'(sample_cnt), 32'd0);
    Finish = 1'b0;
    #2;
    rst = 1'b1;
    step();
    clear_log();
    out_ready = 1'b1;
    WEN = 1'b1; WAddr = 20'd0; Yn = 16'd55;
    step();
    WEN = 1'b0;
    step();
    check("post_rst_seq", 32'(seq_err), 32'd0);
    check("post_rst_cnt", 32'(sample_cnt), 32'd1);
    check("post_rst_nbeats", 32'(qd.size()), 32'd1);
    if (qd.size() == 1)
      check("post_rst_data", 32'(qd[0]), 32'd55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
